// File: rtl/peak_pkg.sv
// Shared definitions for the PEAK decode stage: instruction-vector bit
// positions, RV32I opcodes, immediate formats and the decoded bundle type.
package peak_pkg;

  localparam int unsigned PEAK_INST_W = 40;

  // One-hot instruction vector bit positions
  localparam int unsigned INST_LUI    = 0;
  localparam int unsigned INST_AUIPC  = 1;
  localparam int unsigned INST_JAL    = 2;
  localparam int unsigned INST_JALR   = 3;
  localparam int unsigned INST_BEQ    = 4;
  localparam int unsigned INST_BNE    = 5;
  localparam int unsigned INST_BLT    = 6;
  localparam int unsigned INST_BGE    = 7;
  localparam int unsigned INST_BLTU   = 8;
  localparam int unsigned INST_BGEU   = 9;
  localparam int unsigned INST_LB     = 10;
  localparam int unsigned INST_LH     = 11;
  localparam int unsigned INST_LW     = 12;
  localparam int unsigned INST_LBU    = 13;
  localparam int unsigned INST_LHU    = 14;
  localparam int unsigned INST_SB     = 15;
  localparam int unsigned INST_SH     = 16;
  localparam int unsigned INST_SW     = 17;
  localparam int unsigned INST_ADDI   = 18;
  localparam int unsigned INST_SLTI   = 19;
  localparam int unsigned INST_SLTIU  = 20;
  localparam int unsigned INST_XORI   = 21;
  localparam int unsigned INST_ORI    = 22;
  localparam int unsigned INST_ANDI   = 23;
  localparam int unsigned INST_SLLI   = 24;
  localparam int unsigned INST_SRLI   = 25;
  localparam int unsigned INST_SRAI   = 26;
  localparam int unsigned INST_ADD    = 27;
  localparam int unsigned INST_SUB    = 28;
  localparam int unsigned INST_SLL    = 29;
  localparam int unsigned INST_SLT    = 30;
  localparam int unsigned INST_SLTU   = 31;
  localparam int unsigned INST_XOR    = 32;
  localparam int unsigned INST_SRL    = 33;
  localparam int unsigned INST_SRA    = 34;
  localparam int unsigned INST_OR     = 35;
  localparam int unsigned INST_AND    = 36;
  localparam int unsigned INST_FENCE  = 37;
  localparam int unsigned INST_ECALL  = 38;
  localparam int unsigned INST_EBREAK = 39;

  // Full 7-bit opcodes (bits [1:0] included, so non-32-bit words never match)
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  localparam logic [31:0] WORD_ECALL  = 32'h0000_0073;
  localparam logic [31:0] WORD_EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    ImmI,
    ImmS,
    ImmB,
    ImmU,
    ImmJ,
    ImmNone
  } imm_fmt_t;

  typedef struct packed {
    logic [PEAK_INST_W-1:0] inst;
    logic [4:0]             rd;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [31:0]            imm;
    logic [31:0]            pc;
    logic                   illegal;
  } peak_bundle_t;

endpackage

// File: rtl/peak_decode_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle.
interface peak_decode_if;
  import peak_pkg::*;

  logic                   I_VALID;
  logic                   I_READY;
  logic [31:0]            I_INST;
  logic [31:0]            I_PC;
  logic                   O_VALID;
  logic                   O_READY;
  logic [PEAK_INST_W-1:0] O_INST;
  logic [4:0]             O_RD;
  logic [4:0]             O_RS1;
  logic [4:0]             O_RS2;
  logic [31:0]            O_IMM;
  logic [31:0]            O_PC;
  logic                   O_ILLEGAL;

  // Environment side: drives fetch words and execute ready
  modport master (
    output I_VALID, I_INST, I_PC, O_READY,
    input  I_READY, O_VALID, O_INST, O_RD, O_RS1, O_RS2, O_IMM, O_PC, O_ILLEGAL
  );

  // Decoder side
  modport slave (
    input  I_VALID, I_INST, I_PC, O_READY,
    output I_READY, O_VALID, O_INST, O_RD, O_RS1, O_RS2, O_IMM, O_PC, O_ILLEGAL
  );

endinterface

// File: rtl/peak_decode_comb.sv
// Purely combinational RV32I word -> decoded bundle.
// Optional feature macro: PEAK_DECODE_ILLEGAL_EN (drives the illegal flag).
module peak_decode_comb
  import peak_pkg::*;
(
  input  logic [31:0]  i_inst,
  input  logic [31:0]  i_pc,
  output peak_bundle_t o_bundle
);

  logic [6:0]             w_opcode;
  logic [2:0]             w_funct3;
  logic [6:0]             w_funct7;
  logic [PEAK_INST_W-1:0] w_vec;
  imm_fmt_t               w_fmt;
  logic                   w_shift;
  logic [31:0]            w_imm;

  assign w_opcode = i_inst[6:0];
  assign w_funct3 = i_inst[14:12];
  assign w_funct7 = i_inst[31:25];

  // Opcode/funct decode into the one-hot vector and immediate format
  always_comb begin
    w_vec   = '0;
    w_fmt   = ImmNone;
    w_shift = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        w_fmt = ImmU;
        w_vec[INST_LUI] = 1'b1;
      end
      OPC_AUIPC: begin
        w_fmt = ImmU;
        w_vec[INST_AUIPC] = 1'b1;
      end
      OPC_JAL: begin
        w_fmt = ImmJ;
        w_vec[INST_JAL] = 1'b1;
      end
      OPC_JALR: begin
        w_fmt = ImmI;
        if (w_funct3 == 3'b000) w_vec[INST_JALR] = 1'b1;
      end
      OPC_BRANCH: begin
        w_fmt = ImmB;
        case (w_funct3)
          3'b000:  w_vec[INST_BEQ]  = 1'b1;
          3'b001:  w_vec[INST_BNE]  = 1'b1;
          3'b100:  w_vec[INST_BLT]  = 1'b1;
          3'b101:  w_vec[INST_BGE]  = 1'b1;
          3'b110:  w_vec[INST_BLTU] = 1'b1;
          3'b111:  w_vec[INST_BGEU] = 1'b1;
          default: ;
        endcase
      end
      OPC_LOAD: begin
        w_fmt = ImmI;
        case (w_funct3)
          3'b000:  w_vec[INST_LB]  = 1'b1;
          3'b001:  w_vec[INST_LH]  = 1'b1;
          3'b010:  w_vec[INST_LW]  = 1'b1;
          3'b100:  w_vec[INST_LBU] = 1'b1;
          3'b101:  w_vec[INST_LHU] = 1'b1;
          default: ;
        endcase
      end
      OPC_STORE: begin
        w_fmt = ImmS;
        case (w_funct3)
          3'b000:  w_vec[INST_SB] = 1'b1;
          3'b001:  w_vec[INST_SH] = 1'b1;
          3'b010:  w_vec[INST_SW] = 1'b1;
          default: ;
        endcase
      end
      OPC_OP_IMM: begin
        w_fmt = ImmI;
        case (w_funct3)
          3'b000: w_vec[INST_ADDI]  = 1'b1;
          3'b010: w_vec[INST_SLTI]  = 1'b1;
          3'b011: w_vec[INST_SLTIU] = 1'b1;
          3'b100: w_vec[INST_XORI]  = 1'b1;
          3'b110: w_vec[INST_ORI]   = 1'b1;
          3'b111: w_vec[INST_ANDI]  = 1'b1;
          3'b001: begin
            w_shift = 1'b1;
            if (w_funct7 == FUNCT7_BASE) w_vec[INST_SLLI] = 1'b1;
          end
          3'b101: begin
            w_shift = 1'b1;
            if (w_funct7 == FUNCT7_BASE)     w_vec[INST_SRLI] = 1'b1;
            else if (w_funct7 == FUNCT7_ALT) w_vec[INST_SRAI] = 1'b1;
          end
          default: ;
        endcase
      end
      OPC_OP: begin
        w_fmt = ImmNone;
        if (w_funct7 == FUNCT7_BASE) begin
          case (w_funct3)
            3'b000:  w_vec[INST_ADD]  = 1'b1;
            3'b001:  w_vec[INST_SLL]  = 1'b1;
            3'b010:  w_vec[INST_SLT]  = 1'b1;
            3'b011:  w_vec[INST_SLTU] = 1'b1;
            3'b100:  w_vec[INST_XOR]  = 1'b1;
            3'b101:  w_vec[INST_SRL]  = 1'b1;
            3'b110:  w_vec[INST_OR]   = 1'b1;
            3'b111:  w_vec[INST_AND]  = 1'b1;
            default: ;
          endcase
        end else if (w_funct7 == FUNCT7_ALT) begin
          case (w_funct3)
            3'b000:  w_vec[INST_SUB] = 1'b1;
            3'b101:  w_vec[INST_SRA] = 1'b1;
            default: ;
          endcase
        end
      end
      OPC_MISC_MEM: begin
        w_fmt = ImmI;
        if (w_funct3 == 3'b000) w_vec[INST_FENCE] = 1'b1;
      end
      OPC_SYSTEM: begin
        w_fmt = ImmI;
        if (i_inst == WORD_ECALL)       w_vec[INST_ECALL]  = 1'b1;
        else if (i_inst == WORD_EBREAK) w_vec[INST_EBREAK] = 1'b1;
      end
      default: ;
    endcase
  end

  // Immediate assembly; shift-immediates carry a clean zero-extended shamt
  always_comb begin
    w_imm = '0;
    case (w_fmt)
      ImmI:    w_imm = {{20{i_inst[31]}}, i_inst[31:20]};
      ImmS:    w_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      ImmB:    w_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                        i_inst[11:8], 1'b0};
      ImmU:    w_imm = {i_inst[31:12], 12'b0};
      ImmJ:    w_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                        i_inst[30:21], 1'b0};
      default: w_imm = '0;
    endcase
    if (w_shift) w_imm = {27'b0, i_inst[24:20]};
  end

  assign o_bundle.inst = w_vec;
  assign o_bundle.rd   = i_inst[11:7];
  assign o_bundle.rs1  = i_inst[19:15];
  assign o_bundle.rs2  = i_inst[24:20];
  assign o_bundle.imm  = w_imm;
  assign o_bundle.pc   = i_pc;

`ifdef PEAK_DECODE_ILLEGAL_EN
  assign o_bundle.illegal = ~(|w_vec);
`else
  assign o_bundle.illegal = 1'b0;
`endif

endmodule

// File: rtl/peak_decode.sv
// PEAK decode stage: input-side combinational decode feeding a two-entry
// elastic buffer (output register + skid entry) with a registered ready.
// Optional feature macro: PEAK_DECODE_ILLEGAL_EN (see peak_decode_comb).
module peak_decode
  import peak_pkg::*;
(
  input logic          CLK,
  input logic          RST,
  input logic          FLUSH,
  peak_decode_if.slave bus
);

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } buf_state_t;

  buf_state_t   r_state;
  logic         r_o_valid;
  logic         r_i_ready;
  peak_bundle_t r_or;
  peak_bundle_t r_sk;
  peak_bundle_t w_dec;
  logic         w_accept;

  peak_decode_comb u_comb (
    .i_inst   (bus.I_INST),
    .i_pc     (bus.I_PC),
    .o_bundle (w_dec)
  );

  assign w_accept = bus.I_VALID & r_i_ready;

  // Elastic buffer FSM; valid/ready flags are registered alongside the state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= StEmpty;
      r_o_valid <= 1'b0;
      r_i_ready <= 1'b1;
      r_or      <= '0;
      r_sk      <= '0;
    end else if (FLUSH) begin
      r_state   <= StEmpty;
      r_o_valid <= 1'b0;
      r_i_ready <= 1'b1;
    end else begin
      case (r_state)
        StEmpty: begin
          if (w_accept) begin
            r_or      <= w_dec;
            r_o_valid <= 1'b1;
            r_state   <= StOne;
          end
        end
        StOne: begin
          if (w_accept && bus.O_READY) begin
            r_or <= w_dec;
          end else if (w_accept) begin
            r_sk      <= w_dec;
            r_i_ready <= 1'b0;
            r_state   <= StFull;
          end else if (bus.O_READY) begin
            r_o_valid <= 1'b0;
            r_state   <= StEmpty;
          end
        end
        StFull: begin
          if (bus.O_READY) begin
            r_or      <= r_sk;
            r_i_ready <= 1'b1;
            r_state   <= StOne;
          end
        end
        default: begin
          r_state   <= StEmpty;
          r_o_valid <= 1'b0;
          r_i_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.I_READY   = r_i_ready;
  assign bus.O_VALID   = r_o_valid;
  assign bus.O_INST    = r_or.inst;
  assign bus.O_RD      = r_or.rd;
  assign bus.O_RS1     = r_or.rs1;
  assign bus.O_RS2     = r_or.rs2;
  assign bus.O_IMM     = r_or.imm;
  assign bus.O_PC      = r_or.pc;
  assign bus.O_ILLEGAL = r_or.illegal;

endmodule

// File: doc/peak_decode.md
# peak_decode

Decode stage feeding the PEAK integer ALU. Accepts fetched 32-bit RV32I instruction words with their PC over a valid/ready handshake, decodes them into the one-hot instruction vector, register addresses and sign-extended immediate that the ALU and register file consume, and presents them through a registered two-entry elastic buffer. It sits between fetch and execute, and absorbs one cycle of execute back-pressure without a combinational ready path.

## Interface
Parameters:
- none; all widths are fixed by the RV32I ISA and `peak_pkg`.

Ports (one clock; reset is asynchronous and active-high):
- CLK  input  1  core clock; all state updates on rising edge
- RST  input  1  asynchronous active-high reset
- FLUSH  input  1  synchronous pipeline flush (branch taken or trap)
- I_VALID  input  1  fetch presents a word
- I_READY  output  1  decoder can accept a word; registered
- I_INST  input  32  instruction word
- I_PC  input  32  PC of I_INST
- O_VALID  output  1  decoded bundle valid
- O_READY  input  1  execute consumes the bundle
- O_INST  output  40  one-hot instruction vector; bit positions from `peak_pkg`
- O_RD  output  5  destination register index
- O_RS1  output  5  source 1 index
- O_RS2  output  5  source 2 index
- O_IMM  output  32  sign-extended immediate, 0 for R-type
- O_PC  output  32  PC of the bundle
- O_ILLEGAL  output  1  word is not a legal RV32I encoding

## Operation
- Vector covers 40 ops: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND, FENCE, ECALL, EBREAK. At most one bit is set.
- Immediate formats:
  - I: inst[31:20] sign-extended.
  - S: {inst[31:25],inst[11:7]}.
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}.
  - U: {inst[31:12],12'b0}.
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}.
  - B, S, J and I are sign-extended to 32 bits.
- Shift-immediate: IMM[4:0]=shamt. SRAI is distinguished from SRLI by inst[30]. inst[25] must be 0.
- O_RD, O_RS1 and O_RS2 are always the raw fields inst[11:7], [19:15] and [24:20], regardless of format.
- Elastic buffer: an output register (OR) plus one skid entry (SK).
  - States: EMPTY (OR empty), ONE (OR valid, SK empty), FULL (both valid).
  - Accept = I_VALID & I_READY. I_READY = !SK.valid, taken from the flop.
  - EMPTY + accept -> ONE.
  - ONE + accept & !O_READY -> FULL; the new word goes to SK.
  - ONE + accept & O_READY -> ONE; OR is replaced by the new word.
  - ONE + O_READY & !accept -> EMPTY.
  - FULL + O_READY -> ONE; SK moves to OR. No accept is possible in FULL.
- Order is preserved. No bundle is lost or duplicated.
- FLUSH has priority over every other event. The next edge clears OR.valid and SK.valid, and a word offered in the FLUSH cycle is dropped.

## Timing
- Latency: an accepted word appears on O_* at the next rising edge (1 cycle).
- Throughput: 1 word per cycle while O_READY=1.
- The decode is combinational on the input side only. All O_* outputs are registered.
- Reset values: O_VALID=0, I_READY=1, every data output including O_ILLEGAL is 0, and the buffer is EMPTY.
- Reset asserted mid-stream clears the buffer immediately (asynchronously). No buffered word survives reset.
- O_* data is held stable while O_VALID=1 and O_READY=0.

## Configuration
- `PEAK_DECODE_ILLEGAL_EN`
  - Defined: unrecognised opcode, funct3/funct7 mismatch, or inst[1:0]!=2'b11 gives O_INST=0 and O_ILLEGAL=1. The bundle is still delivered with its PC.
  - Undefined: O_ILLEGAL is tied to 0. Unrecognised words give O_INST=0 and are executed as a no-op.

## Structure
- `peak_pkg` holds:
  - the 40 `localparam` bit indices of the instruction vector, with width constant `PEAK_INST_W=40`;
  - opcode constants;
  - the immediate-format enum (I, S, B, U, J, NONE).
- Sub-module `peak_decode_comb`: purely combinational word->bundle decode. It is instantiated once, on the input side. `peak_decode` holds only the elastic buffer.

## Test plan
- ADDI x1,x2,-1 (0xFFF10093) accepted -> next cycle O_VALID=1, ADDI bit set, O_RD=1, O_RS1=2, O_IMM=0xFFFFFFFF.
- BEQ x0,x0,-4 (0xFE000EE3) -> BEQ bit set, O_IMM=0xFFFFFFFC. LUI x1,0x12345 (0x123450B7) -> O_IMM=0x12345000.
- O_READY=0 with 3 words offered back-to-back -> 2 words accepted and I_READY=0 from cycle 2. Then set O_READY=1 -> words 1, 2, 3 emerge in order with no duplicates.
- FULL, FLUSH=1 and I_VALID=1 in the same cycle -> next cycle O_VALID=0, I_READY=1, and the offered word is never output.
- 0x00000000 -> O_INST=0. O_ILLEGAL=1 with `PEAK_DECODE_ILLEGAL_EN` defined, O_ILLEGAL=0 without it.
- RST asserted while FULL -> O_VALID=0 and I_READY=1 before the next clock edge. After release, the first accepted word decodes correctly.
